// File: rtl/pu_msp430_per_fifo_pkg.sv
// Shared constants for the peripheral-bus FIFO bridge: register offsets,
// CTRL/STATUS bit positions and the FIFO occupancy count width.
package pu_msp430_per_fifo_pkg;

  localparam int CNT_W = 5;

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_STATUS = 3'd1;
  localparam logic [2:0] OFF_LEVEL  = 3'd2;
  localparam logic [2:0] OFF_TXDATA = 3'd3;
  localparam logic [2:0] OFF_RXDATA = 3'd4;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_RX_IE  = 1;
  localparam int CTRL_TX_IE  = 2;
  localparam int CTRL_FLUSH  = 3;

  localparam int ST_RX_EMPTY = 0;
  localparam int ST_RX_FULL  = 1;
  localparam int ST_TX_EMPTY = 2;
  localparam int ST_TX_FULL  = 3;
  localparam int ST_TX_OVF   = 4;
  localparam int ST_RX_UDF   = 5;

  // Bytes not enabled by per_we are pushed as zero.
  function automatic logic [15:0] merge_bytes(input logic [15:0] din, input logic [1:0] we);
    return {we[1] ? din[15:8] : 8'h00, we[0] ? din[7:0] : 8'h00};
  endfunction

endpackage

// File: rtl/pu_msp430_sync_fifo.sv
// Single-clock word FIFO with flush; push to full and pop from empty are
// ignored, so callers may present requests without pre-qualifying them.
module pu_msp430_sync_fifo
  import pu_msp430_per_fifo_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             mclk,
  input  logic             puc_rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [15:0]      din,
  output logic [15:0]      head,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [15:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign head    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // NOTE: storage is reset too, so the head (and fifo_tx_data) reads 0 after reset
  // instead of X; this makes the array plain flops rather than an inferred RAM.
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pu_msp430_per_fifo.sv
// Peripheral-bus responder exposing a TX FIFO (CPU -> stream) and an RX FIFO
// (stream -> CPU). Interrupt logic is built only when FIFO_IRQ_EN is defined.
module pu_msp430_per_fifo
  import pu_msp430_per_fifo_pkg::*;
#(
  parameter logic [14:0] BASE_ADDR = 15'h0190,
  parameter int          DEPTH     = 4
) (
  input  logic        mclk,
  input  logic        puc_rst,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  input  logic [1:0]  per_we,
  input  logic        per_en,
  output logic [15:0] per_dout,
  output logic [15:0] fifo_tx_data,
  output logic        fifo_tx_valid,
  input  logic        fifo_tx_ready,
  input  logic [15:0] fifo_rx_data,
  input  logic        fifo_rx_valid,
  output logic        fifo_rx_ready,
  output logic        fifo_irq
);

  logic             reg_sel, reg_wr, reg_rd;
  logic [2:0]       off;
  logic             ctrl_enable, ctrl_rx_ie, ctrl_tx_ie;
  logic             tx_ovf, rx_udf;
  logic             flush;
  logic             tx_push, tx_pop, rx_push, rx_pop;
  logic             status_w1c;
  logic [15:0]      tx_head, rx_head;
  logic             tx_empty, tx_full, rx_empty, rx_full;
  logic [CNT_W-1:0] tx_cnt, rx_cnt;
  logic [15:0]      rd_data;

  assign reg_sel = per_en & (per_addr[13:3] == BASE_ADDR[14:4]);
  assign reg_wr  = reg_sel & (|per_we);
  assign reg_rd  = reg_sel & ~(|per_we);
  assign off     = per_addr[2:0];

  // FLUSH is a decoded strobe, never stored, which is why it reads back 0.
  assign flush      = reg_wr & (off == OFF_CTRL) & per_we[0] & per_din[CTRL_FLUSH];
  assign status_w1c = reg_wr & (off == OFF_STATUS) & per_we[0];
  assign tx_push    = reg_wr & (off == OFF_TXDATA);
  assign rx_pop     = reg_rd & (off == OFF_RXDATA);

  assign fifo_tx_valid = ctrl_enable & ~tx_empty;
  assign fifo_rx_ready = ctrl_enable & ~rx_full;
  assign tx_pop        = fifo_tx_valid & fifo_tx_ready;
  assign rx_push       = fifo_rx_valid & fifo_rx_ready;
  assign fifo_tx_data  = tx_head;

  pu_msp430_sync_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .mclk    (mclk),
    .puc_rst (puc_rst),
    .flush   (flush),
    .push    (tx_push),
    .pop     (tx_pop),
    .din     (merge_bytes(per_din, per_we)),
    .head    (tx_head),
    .empty   (tx_empty),
    .full    (tx_full),
    .count   (tx_cnt)
  );

  pu_msp430_sync_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .mclk    (mclk),
    .puc_rst (puc_rst),
    .flush   (flush),
    .push    (rx_push),
    .pop     (rx_pop),
    .din     (fifo_rx_data),
    .head    (rx_head),
    .empty   (rx_empty),
    .full    (rx_full),
    .count   (rx_cnt)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      ctrl_enable <= 1'b0;
      tx_ovf      <= 1'b0;
      rx_udf      <= 1'b0;
    end else begin
      if (reg_wr && off == OFF_CTRL && per_we[0]) ctrl_enable <= per_din[CTRL_ENABLE];
      if (tx_push && tx_full)                     tx_ovf <= 1'b1;
      else if (status_w1c && per_din[ST_TX_OVF])  tx_ovf <= 1'b0;
      if (rx_pop && rx_empty)                     rx_udf <= 1'b1;
      else if (status_w1c && per_din[ST_RX_UDF])  rx_udf <= 1'b0;
    end
  end

`ifdef FIFO_IRQ_EN
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      ctrl_rx_ie <= 1'b0;
      ctrl_tx_ie <= 1'b0;
      fifo_irq   <= 1'b0;
    end else begin
      if (reg_wr && off == OFF_CTRL && per_we[0]) begin
        ctrl_rx_ie <= per_din[CTRL_RX_IE];
        ctrl_tx_ie <= per_din[CTRL_TX_IE];
      end
      fifo_irq <= (ctrl_rx_ie & ~rx_empty) | (ctrl_tx_ie & tx_empty) | tx_ovf | rx_udf;
    end
  end
`else
  assign ctrl_rx_ie = 1'b0;
  assign ctrl_tx_ie = 1'b0;
  assign fifo_irq   = 1'b0;
`endif

  // NOTE: rd_data gets a default before the case so no path infers a latch.
  always_comb begin
    rd_data = '0;
    case (off)
      OFF_CTRL: begin
        rd_data[CTRL_ENABLE] = ctrl_enable;
        rd_data[CTRL_RX_IE]  = ctrl_rx_ie;
        rd_data[CTRL_TX_IE]  = ctrl_tx_ie;
      end
      OFF_STATUS: begin
        rd_data[ST_RX_EMPTY] = rx_empty;
        rd_data[ST_RX_FULL]  = rx_full;
        rd_data[ST_TX_EMPTY] = tx_empty;
        rd_data[ST_TX_FULL]  = tx_full;
        rd_data[ST_TX_OVF]   = tx_ovf;
        rd_data[ST_RX_UDF]   = rx_udf;
      end
      OFF_LEVEL: begin
        rd_data[12:8] = tx_cnt;
        rd_data[4:0]  = rx_cnt;
      end
      OFF_RXDATA: rd_data = rx_empty ? 16'h0000 : rx_head;
      default:    rd_data = '0;
    endcase
  end

  // Forced to 0 outside reads so the bus OR-tree sees nothing from this block.
  assign per_dout = (reg_rd & ~puc_rst) ? rd_data : 16'h0000;

endmodule
